// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame receiver.
// FSM states, error cause codes and the default start-of-frame byte.
package uart_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    PAYLOAD,
    CHK,
    DRAIN
  } state_t;

  localparam logic [1:0] ERR_LEN = 2'b01;
  localparam logic [1:0] ERR_CHK = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  localparam logic [7:0] SOF_DEFAULT = 8'h7E;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Payload byte stream between the frame receiver and its consumer.
// master drives data/valid/last, slave drives ready.
interface uart_frame_rx_if;

  logic [7:0] M_TDATA;
  logic       M_TVALID;
  logic       M_TREADY;
  logic       M_TLAST;

  modport master (
    output M_TDATA,
    output M_TVALID,
    output M_TLAST,
    input  M_TREADY
  );

  modport slave (
    input  M_TDATA,
    input  M_TVALID,
    input  M_TLAST,
    output M_TREADY
  );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload store: one synchronous write port, one async read port.
// Contents are not reset.
module uart_frame_buf #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_frame_rx.sv
// Store-and-forward length/checksum frame decoder after the UART RX FIFO.
// Optional inter-byte timeout: define UART_FRAME_TIMEOUT_EN.
module uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter int         MAX_LEN        = 64,
  parameter logic [7:0] SOF            = SOF_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 100000
) (
  input  logic       CLK,
  input  logic       RESET,
  output logic       FIFO_RDEN,
  input  logic       FIFO_EMPTY,
  input  logic [7:0] FIFO_DIN,
  uart_frame_rx_if.master m,
  output logic       FRAME_OK,
  output logic       FRAME_ERR,
  output logic [1:0] ERR_CODE
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int BW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAXB = 8'(MAX_LEN);

  state_t state, state_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] idx, idx_n;
  logic [LW-1:0] rd, rd_n;
  logic [7:0] sum, sum_n;
  logic [7:0] chk_sum;
  logic vld;
  logic ok_n, err_n;
  logic [1:0] code_n;
  logic last;
  logic [7:0] rdata;

  // vld marks the cycle FIFO_DIN holds the byte read last cycle
  assign FIFO_RDEN = !RESET && (state != DRAIN)
                   && !FIFO_EMPTY && !vld;

  assign chk_sum = sum + FIFO_DIN;
  assign last = (rd == len - LW'(1));

  assign m.M_TVALID = (state == DRAIN);
  assign m.M_TDATA = m.M_TVALID ? rdata : 8'h00;
  assign m.M_TLAST = m.M_TVALID && last;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic in_frame;
  logic tmo_hit;

  assign in_frame = (state == LEN) || (state == PAYLOAD)
                  || (state == CHK);
  assign tmo_hit = in_frame && !vld
                 && (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (RESET || !in_frame || vld) tmo <= '0;
    else if (!tmo_hit) tmo <= tmo + TW'(1);
  end
`endif

  always_comb begin
    state_n = state;
    len_n = len;
    idx_n = idx;
    rd_n = rd;
    sum_n = sum;
    ok_n = 1'b0;
    err_n = 1'b0;
    code_n = 2'b00;
    unique case (state)
      IDLE: begin
        if (vld && FIFO_DIN == SOF) state_n = LEN;
      end
      LEN: begin
        if (vld) begin
          if (FIFO_DIN == 8'h00 || FIFO_DIN > MAXB) begin
            err_n = 1'b1;
            code_n = ERR_LEN;
            state_n = IDLE;
          end else begin
            len_n = FIFO_DIN[LW-1:0];
            sum_n = FIFO_DIN;
            idx_n = '0;
            state_n = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (vld) begin
          sum_n = sum + FIFO_DIN;
          idx_n = idx + LW'(1);
          if (idx_n == len) state_n = CHK;
        end
      end
      CHK: begin
        if (vld) begin
          if (chk_sum == 8'h00) begin
            ok_n = 1'b1;
            rd_n = '0;
            state_n = DRAIN;
          end else begin
            err_n = 1'b1;
            code_n = ERR_CHK;
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (m.M_TREADY) begin
          if (last) state_n = IDLE;
          else rd_n = rd + LW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
`ifdef UART_FRAME_TIMEOUT_EN
    if (tmo_hit) begin
      err_n = 1'b1;
      code_n = ERR_TMO;
      state_n = IDLE;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      len <= '0;
      idx <= '0;
      rd <= '0;
      sum <= '0;
      vld <= 1'b0;
      FRAME_OK <= 1'b0;
      FRAME_ERR <= 1'b0;
      ERR_CODE <= 2'b00;
    end else begin
      state <= state_n;
      len <= len_n;
      idx <= idx_n;
      rd <= rd_n;
      sum <= sum_n;
      vld <= FIFO_RDEN;
      FRAME_OK <= ok_n;
      FRAME_ERR <= err_n;
      ERR_CODE <= code_n;
    end
  end

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BW)
  ) u_buf (
    .CLK   (CLK),
    .we    (state == PAYLOAD && vld),
    .waddr (idx[BW-1:0]),
    .wdata (FIFO_DIN),
    .raddr (rd[BW-1:0]),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_uart_frame_rx.sv
// Bench for uart_frame_rx: FIFO model, stream sink, vector table.
// Build with UART_FRAME_TIMEOUT_EN to cover the timeout path.
module tb_uart_frame_rx;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  logic FIFO_RDEN;
  logic FIFO_EMPTY = 1'b1;
  logic [7:0] FIFO_DIN = 8'h00;
  logic FRAME_OK, FRAME_ERR;
  logic [1:0] ERR_CODE;

  uart_frame_rx_if s_if();

  uart_frame_rx #(
    .MAX_LEN        (8),
    .SOF            (8'h7E),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .FIFO_RDEN  (FIFO_RDEN),
    .FIFO_EMPTY (FIFO_EMPTY),
    .FIFO_DIN   (FIFO_DIN),
    .m          (s_if),
    .FRAME_OK   (FRAME_OK),
    .FRAME_ERR  (FRAME_ERR),
    .ERR_CODE   (ERR_CODE)
  );

  always #5 CLK = ~CLK;

  logic [7:0] fq[$];
  logic rdy_pat[$];
  logic [7:0] outd[$];
  logic outl[$];
  int okc, errc, both, drain_rd, rd_empty, unstable;
  logic [1:0] last_code;
  int cyc = 0, pop_cyc = 0, err_cyc = 0;
  logic stall = 1'b0;
  logic [7:0] pd = 8'h00;
  logic pl = 1'b0;
  int checks = 0, errors = 0;

  always @(posedge CLK) begin
    cyc++;
    if (FIFO_RDEN) begin
      if (s_if.M_TVALID) drain_rd++;
      if (fq.size() == 0) rd_empty++;
      else FIFO_DIN <= fq.pop_front();
      pop_cyc = cyc;
    end
  end

  always @(negedge CLK) begin
    logic rdy;
    if (!RESET) begin
      if (FRAME_OK) okc++;
      if (FRAME_ERR) begin
        errc++;
        last_code = ERR_CODE;
        err_cyc = cyc;
      end
      if (FRAME_OK && FRAME_ERR) both++;
      if (stall && (s_if.M_TDATA !== pd || s_if.M_TLAST !== pl))
        unstable++;
    end
    rdy = 1'b1;
    if (s_if.M_TVALID && rdy_pat.size() > 0)
      rdy = rdy_pat.pop_front();
    s_if.M_TREADY = rdy;
    if (s_if.M_TVALID && rdy) begin
      outd.push_back(s_if.M_TDATA);
      outl.push_back(s_if.M_TLAST);
    end
    stall = s_if.M_TVALID && !rdy;
    pd = s_if.M_TDATA;
    pl = s_if.M_TLAST;
    FIFO_EMPTY = (fq.size() == 0);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic clr();
    okc = 0; errc = 0; both = 0; drain_rd = 0;
    rd_empty = 0; unstable = 0; last_code = 2'b00;
    outd.delete();
    outl.delete();
  endtask

  task automatic do_reset(bit check_zero);
    @(negedge CLK);
    RESET = 1'b1;
    fq.delete();
    rdy_pat.delete();
    @(negedge CLK);
    if (check_zero) begin
      chk("rst_rden", FIFO_RDEN, 0);
      chk("rst_tvalid", s_if.M_TVALID, 0);
      chk("rst_tlast", s_if.M_TLAST, 0);
      chk("rst_tdata", s_if.M_TDATA, 0);
      chk("rst_ok", FRAME_OK, 0);
      chk("rst_err", FRAME_ERR, 0);
      chk("rst_code", ERR_CODE, 0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    clr();
  endtask

  task automatic wait_idle(string nm);
    int quiet = 0;
    for (int c = 0; c < 3000 && quiet < 6; c++) begin
      @(negedge CLK);
      if (fq.size() == 0 && !s_if.M_TVALID && !FIFO_RDEN)
        quiet++;
      else
        quiet = 0;
    end
    chk({nm, "_idle"}, quiet >= 6, 1);
  endtask

  task automatic check_common(string nm);
    chk({nm, "_both"}, both, 0);
    chk({nm, "_drain_rd"}, drain_rd, 0);
    chk({nm, "_rd_empty"}, rd_empty, 0);
    chk({nm, "_unstable"}, unstable, 0);
  endtask

  typedef struct {
    string name;
    int n;
    logic [7:0] b [16];
    int nout;
    logic [7:0] o [16];
    int nok;
    int nerr;
    logic [1:0] code;
  } vec_t;

  vec_t vt [7];

  task automatic check_out(string nm, vec_t v);
    chk({nm, "_nout"}, outd.size(), v.nout);
    for (int k = 0; k < v.nout && k < outd.size(); k++) begin
      chk($sformatf("%s_d%0d", nm, k), outd[k], v.o[k]);
      chk($sformatf("%s_l%0d", nm, k), outl[k], k == v.nout - 1);
    end
  endtask

  initial begin
    vt[0] = '{"good3", 6,
      '{0:8'h7E, 1:8'h03, 2:8'h11, 3:8'h22, 4:8'h33, 5:8'h97,
        default:8'h00},
      3, '{0:8'h11, 1:8'h22, 2:8'h33, default:8'h00}, 1, 0, 2'b00};
    vt[1] = '{"badchk", 10,
      '{0:8'h7E, 1:8'h03, 2:8'h11, 3:8'h22, 4:8'h33, 5:8'h98,
        6:8'h7E, 7:8'h01, 8:8'hAA, 9:8'h55, default:8'h00},
      1, '{0:8'hAA, default:8'h00}, 1, 1, 2'b10};
    vt[2] = '{"garbage", 8,
      '{0:8'h00, 1:8'hFF, 2:8'h7E, 3:8'h00, 4:8'h7E, 5:8'h01,
        6:8'h05, 7:8'hFA, default:8'h00},
      1, '{0:8'h05, default:8'h00}, 1, 1, 2'b01};
    vt[3] = '{"len_over", 2,
      '{0:8'h7E, 1:8'h09, default:8'h00},
      0, '{default:8'h00}, 0, 1, 2'b01};
    vt[4] = '{"len_max", 11,
      '{0:8'h7E, 1:8'h08, 2:8'h01, 3:8'h02, 4:8'h03, 5:8'h04,
        6:8'h05, 7:8'h06, 8:8'h07, 9:8'h08, 10:8'hD4,
        default:8'h00},
      8, '{0:8'h01, 1:8'h02, 2:8'h03, 3:8'h04, 4:8'h05, 5:8'h06,
        6:8'h07, 7:8'h08, default:8'h00}, 1, 0, 2'b00};
    vt[5] = '{"sof_len", 2,
      '{0:8'h7E, 1:8'h7E, default:8'h00},
      0, '{default:8'h00}, 0, 1, 2'b01};
    vt[6] = '{"sof_data", 5,
      '{0:8'h7E, 1:8'h02, 2:8'h7E, 3:8'h01, 4:8'h7F,
        default:8'h00},
      2, '{0:8'h7E, 1:8'h01, default:8'h00}, 1, 0, 2'b00};

    s_if.M_TREADY = 1'b1;
    clr();
    do_reset(1);

    for (int i = 0; i < 7; i++) begin
      clr();
      for (int j = 0; j < vt[i].n; j++) fq.push_back(vt[i].b[j]);
      wait_idle(vt[i].name);
      check_out(vt[i].name, vt[i]);
      chk({vt[i].name, "_ok"}, okc, vt[i].nok);
      chk({vt[i].name, "_err"}, errc, vt[i].nerr);
      if (vt[i].nerr > 0)
        chk({vt[i].name, "_code"}, last_code, vt[i].code);
      check_common(vt[i].name);
    end

    // back-pressure while draining
    clr();
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int j = 0; j < 6; j++) fq.push_back(vt[0].b[j]);
    wait_idle("stall");
    check_out("stall", vt[0]);
    chk("stall_ok", okc, 1);
    chk("stall_err", errc, 0);
    check_common("stall");

    // reset in the middle of a payload
    clr();
    fq = '{8'h7E, 8'h05, 8'h01, 8'h02};
    for (int c = 0; c < 50 && fq.size() > 0; c++) @(negedge CLK);
    repeat (3) @(negedge CLK);
    do_reset(0);
    for (int j = 0; j < 6; j++) fq.push_back(vt[0].b[j]);
    wait_idle("midrst");
    check_out("midrst", vt[0]);
    chk("midrst_ok", okc, 1);
    chk("midrst_err", errc, 0);
    check_common("midrst");

    // partial frame, then silence
    clr();
    fq = '{8'h7E, 8'h04, 8'h01};
`ifdef UART_FRAME_TIMEOUT_EN
    for (int c = 0; c < 300 && errc == 0; c++) @(negedge CLK);
    chk("tmo_err", errc, 1);
    chk("tmo_code", last_code, 2'b11);
    chk("tmo_delay", err_cyc - pop_cyc, 51);
    chk("tmo_nout", outd.size(), 0);
`else
    repeat (300) @(negedge CLK);
    chk("notmo_err", errc, 0);
    chk("notmo_nout", outd.size(), 0);
`endif
    check_common("tmo");
    do_reset(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
